// File: rtl/gray_fifo_pkg.sv
// rtl/gray_fifo_pkg.sv - shared pointer-width derivation and Gray decode helper
package gray_fifo_pkg;

  localparam int GRAY_CHK_W = 32;

  function automatic int ptr_width(input int vec_w);
    return vec_w + 1;
  endfunction

  // Decodes a zero-extended Gray value; used to cross-check pointer encodings.
  function automatic logic [GRAY_CHK_W-1:0] gray_to_bin(input logic [GRAY_CHK_W-1:0] gray);
    logic [GRAY_CHK_W-1:0] bin;
    bin[GRAY_CHK_W-1] = gray[GRAY_CHK_W-1];
    for (int i = GRAY_CHK_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/Binary_to_Gray.sv
// rtl/Binary_to_Gray.sv - combinational binary to reflected Gray code converter
module Binary_to_Gray #(
  parameter int VEC_W = 4
) (
  input  logic [VEC_W-1:0] bin_i,
  output logic [VEC_W-1:0] gray_o
);

  assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/gray_fifo_ctrl.sv
// rtl/gray_fifo_ctrl.sv - single-clock FIFO controller with registered Gray pointers
module gray_fifo_ctrl
  import gray_fifo_pkg::*;
#(
  parameter int VEC_W = 4,
  localparam int PTR_W = ptr_width(VEC_W)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             wr_valid_i,
  output logic             wr_ready_o,
  output logic             wr_en_o,
  output logic [VEC_W-1:0] wr_addr_o,
  output logic             rd_valid_o,
  input  logic             rd_ready_i,
  output logic [VEC_W-1:0] rd_addr_o,
  output logic [PTR_W-1:0] wr_ptr_gray_o,
  output logic [PTR_W-1:0] rd_ptr_gray_o,
  output logic [PTR_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  // Full when pointers differ by exactly the depth: Gray form flips the two MSBs.
  localparam logic [PTR_W-1:0] FULL_XOR = PTR_W'(3) << (PTR_W - 2);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_gray_q, wr_gray_d;
  logic [PTR_W-1:0] rd_gray_q, rd_gray_d;
  logic             push, pop;
  logic             full, empty;

  assign empty = (wr_gray_q == rd_gray_q);
  assign full  = (wr_gray_q == (rd_gray_q ^ FULL_XOR));

  always_comb begin
    push     = wr_valid_i & ~full;
    pop      = rd_ready_i & ~empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (!rst_ni || clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  // Gray pointers are encoded from the next binary value so they update in lockstep.
  Binary_to_Gray #(.VEC_W(PTR_W)) u_wr_b2g (
    .bin_i  (wr_ptr_d),
    .gray_o (wr_gray_d)
  );

  Binary_to_Gray #(.VEC_W(PTR_W)) u_rd_b2g (
    .bin_i  (rd_ptr_d),
    .gray_o (rd_gray_d)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      wr_gray_q <= '0;
      rd_gray_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_gray_q <= wr_gray_d;
      rd_gray_q <= rd_gray_d;
    end
  end

  assign wr_ready_o    = ~full;
  assign rd_valid_o    = ~empty;
  assign wr_en_o       = push & ~clear_i & rst_ni;
  assign wr_addr_o     = wr_ptr_q[VEC_W-1:0];
  assign rd_addr_o     = rd_ptr_q[VEC_W-1:0];
  assign wr_ptr_gray_o = wr_gray_q;
  assign rd_ptr_gray_o = rd_gray_q;
  assign count_o       = wr_ptr_q - rd_ptr_q;
  assign full_o        = full;
  assign empty_o       = empty;

endmodule

// File: tb/tb_gray_fifo_ctrl.sv
// tb/tb_gray_fifo_ctrl.sv - scoreboard bench for gray_fifo_ctrl at VEC_W=4
module tb_gray_fifo_ctrl;
  import gray_fifo_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       clear_i = 1'b0;
  logic       wr_valid_i = 1'b0;
  logic       rd_ready_i = 1'b0;
  logic       wr_ready_o, wr_en_o, rd_valid_o, full_o, empty_o;
  logic [3:0] wr_addr_o, rd_addr_o;
  logic [4:0] wr_ptr_gray_o, rd_ptr_gray_o, count_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  gray_fifo_ctrl #(.VEC_W(4)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .clear_i       (clear_i),
    .wr_valid_i    (wr_valid_i),
    .wr_ready_o    (wr_ready_o),
    .wr_en_o       (wr_en_o),
    .wr_addr_o     (wr_addr_o),
    .rd_valid_o    (rd_valid_o),
    .rd_ready_i    (rd_ready_i),
    .rd_addr_o     (rd_addr_o),
    .wr_ptr_gray_o (wr_ptr_gray_o),
    .rd_ptr_gray_o (rd_ptr_gray_o),
    .count_o       (count_o),
    .full_o        (full_o),
    .empty_o       (empty_o)
  );

  typedef struct {
    logic       wr_ready, rd_valid, wr_en, full, empty;
    logic [3:0] wa, ra;
    logic [4:0] wg, rg, cnt, wbin, rbin;
    bit         ham;
    bit         winc, rinc;
  } exp_t;

  typedef struct {
    string      name;
    logic [4:0] cnt, wg, rg;
    logic       full, empty, wr_ready, wr_en;
  } hand_t;

  exp_t  exp_q[$];
  hand_t hand_q[$];

  logic [4:0] mw = '0, mr = '0;
  bit         last_plain = 1'b0, last_winc = 1'b0, last_rinc = 1'b0;

  function automatic logic [4:0] to_gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus: queue the model's view of this cycle, then advance the model.
  task automatic step(input logic wv, input logic rr, input logic clr, input logic rstn);
    exp_t       e;
    logic [4:0] cnt;
    bit         push_m, pop_m;
    @(posedge clk_i);
    #1;
    wr_valid_i = wv;
    rd_ready_i = rr;
    clear_i    = clr;
    rst_ni     = rstn;
    cnt        = mw - mr;
    e.full     = (cnt == 5'd16);
    e.empty    = (cnt == 5'd0);
    e.wr_ready = ~e.full;
    e.rd_valid = ~e.empty;
    push_m     = rstn && !clr && wv && !e.full;
    pop_m      = rstn && !clr && rr && !e.empty;
    e.wr_en    = push_m;
    e.wa       = mw[3:0];
    e.ra       = mr[3:0];
    e.wg       = to_gray(mw);
    e.rg       = to_gray(mr);
    e.cnt      = cnt;
    e.wbin     = mw;
    e.rbin     = mr;
    e.ham      = last_plain;
    e.winc     = last_winc;
    e.rinc     = last_rinc;
    exp_q.push_back(e);
    if (!rstn || clr) begin
      mw = '0;
      mr = '0;
    end else begin
      if (push_m) mw = mw + 5'd1;
      if (pop_m)  mr = mr + 5'd1;
    end
    last_plain = rstn && !clr;
    last_winc  = push_m;
    last_rinc  = pop_m;
  endtask

  task automatic hand(input string nm, input logic [4:0] cnt, input logic [4:0] wg,
                      input logic [4:0] rg, input logic full, input logic empty,
                      input logic wready, input logic wen);
    hand_t h;
    h.name = nm; h.cnt = cnt; h.wg = wg; h.rg = rg;
    h.full = full; h.empty = empty; h.wr_ready = wready; h.wr_en = wen;
    hand_q.push_back(h);
  endtask

  logic [4:0] prev_wg, prev_rg;
  bit         have_prev = 1'b0;

  initial begin : monitor
    exp_t  e;
    hand_t h;
    forever begin
      @(negedge clk_i);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("wr_ready", 32'(wr_ready_o), 32'(e.wr_ready));
        chk("rd_valid", 32'(rd_valid_o), 32'(e.rd_valid));
        chk("wr_en", 32'(wr_en_o), 32'(e.wr_en));
        chk("full", 32'(full_o), 32'(e.full));
        chk("empty", 32'(empty_o), 32'(e.empty));
        chk("wr_addr", 32'(wr_addr_o), 32'(e.wa));
        chk("rd_addr", 32'(rd_addr_o), 32'(e.ra));
        chk("wr_gray", 32'(wr_ptr_gray_o), 32'(e.wg));
        chk("rd_gray", 32'(rd_ptr_gray_o), 32'(e.rg));
        chk("count", 32'(count_o), 32'(e.cnt));
        chk("wr_gray_decode", gray_to_bin(32'(wr_ptr_gray_o)), 32'(e.wbin));
        chk("rd_gray_decode", gray_to_bin(32'(rd_ptr_gray_o)), 32'(e.rbin));
        if (e.ham && have_prev) begin
          chk("wr_gray_hamming", $countones(prev_wg ^ wr_ptr_gray_o), 32'(e.winc));
          chk("rd_gray_hamming", $countones(prev_rg ^ rd_ptr_gray_o), 32'(e.rinc));
        end
        prev_wg   = wr_ptr_gray_o;
        prev_rg   = rd_ptr_gray_o;
        have_prev = 1'b1;
      end
      while (hand_q.size() > 0) begin
        h = hand_q.pop_front();
        chk({h.name, "_count"}, 32'(count_o), 32'(h.cnt));
        chk({h.name, "_wr_gray"}, 32'(wr_ptr_gray_o), 32'(h.wg));
        chk({h.name, "_rd_gray"}, 32'(rd_ptr_gray_o), 32'(h.rg));
        chk({h.name, "_full"}, 32'(full_o), 32'(h.full));
        chk({h.name, "_empty"}, 32'(empty_o), 32'(h.empty));
        chk({h.name, "_wr_ready"}, 32'(wr_ready_o), 32'(h.wr_ready));
        chk({h.name, "_wr_en"}, 32'(wr_en_o), 32'(h.wr_en));
      end
    end
  end

  initial begin : watchdog
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : driver
    repeat (2) @(posedge clk_i);
    // Still in reset, with a push request that must not strobe storage.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    hand("reset", 5'd0, 5'b00000, 5'b00000, 1'b0, 1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    hand("fill", 5'd16, 5'b11000, 5'b00000, 1'b1, 1'b0, 1'b0, 1'b0);

    step(1'b1, 1'b1, 1'b0, 1'b1);
    hand("full_pop", 5'd16, 5'b11000, 5'b00000, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    hand("after_full_pop", 5'd15, 5'b11000, 5'b00001, 1'b0, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    hand("simul", 5'd5, 5'b10111, 5'b11111, 1'b0, 1'b0, 1'b1, 1'b0);

    step(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b1);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    hand("wrap", 5'd0, 5'b01100, 5'b01100, 1'b0, 1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    hand("clear_cycle", 5'd9, 5'b11001, 5'b01100, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    hand("after_clear", 5'd0, 5'b00000, 5'b00000, 1'b0, 1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    hand("reset_cycle", 5'd3, 5'b00010, 5'b00000, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    hand("after_reset", 5'd0, 5'b00000, 5'b00000, 1'b0, 1'b1, 1'b1, 1'b0);

    repeat (2) @(negedge clk_i);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size() + hand_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gray_fifo_ctrl.md
GRAY_FIFO_CTRL -- requirements
Module: gray_fifo_ctrl

Interface
REQ-001 SHALL have parameter VEC_W, default 4: address width; FIFO depth = 2**VEC_W; pointer width PTR_W = VEC_W+1.
REQ-002 SHALL have port clk_i, input, 1: single clock; all state on rising edge.
REQ-003 SHALL have port rst_ni, input, 1: one clock; reset is synchronous and active-low.
REQ-004 SHALL have port clear_i, input, 1: synchronous flush request.
REQ-005 SHALL have port wr_valid_i, input, 1: producer push request.
REQ-006 SHALL have port wr_ready_o, output, 1: push accepted when high.
REQ-007 SHALL have port wr_en_o, output, 1: storage write strobe.
REQ-008 SHALL have port wr_addr_o, output, VEC_W: storage write address.
REQ-009 SHALL have port rd_valid_o, output, 1: entry available.
REQ-010 SHALL have port rd_ready_i, input, 1: consumer pop request.
REQ-011 SHALL have port rd_addr_o, output, VEC_W: storage read address (asynchronous-read storage).
REQ-012 SHALL have port wr_ptr_gray_o, output, PTR_W: registered Gray write pointer.
REQ-013 SHALL have port rd_ptr_gray_o, output, PTR_W: registered Gray read pointer.
REQ-014 SHALL have port count_o, output, PTR_W: occupancy, 0..2**VEC_W.
REQ-015 SHALL have ports full_o and empty_o, output, 1 each: status flags.

Function
REQ-016 SHALL hold binary pointers wr_ptr and rd_ptr of PTR_W bits, incrementing modulo 2**PTR_W.
REQ-017 SHALL define push = wr_valid_i & wr_ready_o, and pop = rd_valid_o & rd_ready_i.
REQ-018 SHALL drive wr_ready_o = ~full_o and rd_valid_o = ~empty_o, combinationally from registered state.
REQ-019 SHALL drive wr_en_o = push, wr_addr_o = wr_ptr[VEC_W-1:0], and rd_addr_o = rd_ptr[VEC_W-1:0].
REQ-020 SHALL register wr_ptr_gray_o and rd_ptr_gray_o from the Gray conversion of the next binary pointer, so each Gray pointer changes in the same cycle as its binary pointer, with zero extra latency.
REQ-021 SHALL assert empty_o when wr_ptr_gray_o == rd_ptr_gray_o.
REQ-022 SHALL assert full_o when wr_ptr_gray_o equals rd_ptr_gray_o with its two MSBs inverted and all other bits equal.
REQ-023 SHALL make count_o = wr_ptr - rd_ptr (PTR_W bits); full_o and empty_o SHALL always agree with count_o == 2**VEC_W and count_o == 0 respectively.
REQ-024 SHALL, on simultaneous push and pop, advance both pointers and leave count_o unchanged.
REQ-025 SHALL block push when full, even if a pop occurs in the same cycle (wr_ready_o is not bypassed).
REQ-026 SHALL suppress pop when empty; a push into an empty FIFO becomes visible on rd_valid_o the following cycle.
REQ-027 SHALL give clear_i priority over push and pop: next cycle all pointers are 0 and wr_en_o is 0 during the clear cycle.
REQ-028 SHALL change each Gray pointer by exactly one bit per increment, including the wrap from 2**PTR_W-1 to 0.

Reset
REQ-029 SHALL, while rst_ni is low at a clock edge, set wr_ptr, rd_ptr, both Gray pointers and count_o to 0, with empty_o=1, full_o=0, wr_ready_o=1, rd_valid_o=0 and wr_en_o=0.
REQ-030 SHALL, on reset asserted mid-operation, discard all contents regardless of push or pop in that cycle; reset takes priority over clear_i.

Structure
REQ-031 SHALL place the PTR_W derivation and a Gray-to-binary check function in shared package gray_fifo_pkg.
REQ-032 SHALL instantiate the existing Binary_to_Gray sub-module twice with VEC_W set to PTR_W, one for the write pointer and one for the read pointer; no other sub-module.

Verification (VEC_W=4)
REQ-033 SHALL cover reset: after rst_ni low for 2 cycles -> empty_o=1, full_o=0, count_o=0, both Gray pointers 00000.
REQ-034 SHALL cover fill: 16 pushes from empty -> full_o=1, count_o=16, wr_ptr_gray_o=11000, wr_ready_o=0; a 17th wr_valid_i produces no wr_en_o.
REQ-035 SHALL cover simultaneous traffic: at count 5, push+pop for 10 cycles -> count_o stays 5 and both pointers advance by 10.
REQ-036 SHALL cover wrap: 40 push/pop pairs -> every Gray transition has Hamming distance 1, and both pointers end at binary 01000, Gray 01100.
REQ-037 SHALL cover clear mid-operation: count 9, then clear_i with push and pop asserted -> next cycle count_o=0, empty_o=1, both Gray pointers 00000.
REQ-038 SHALL cover full plus pop: at count 16, wr_valid_i and rd_ready_i both high -> pop only, count_o=15, and the next cycle wr_ready_o=1.
